// File: rtl/alu_op_issuer_if.sv
// Request/response handshake bundle for the ALU operation issuer.
// master = requester side, slave = issuer side.
interface alu_op_issuer_if #(
    parameter int W = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Sequencer driving a combinational 8-bit ALU macro from registers,
// waiting a per-opcode settle time before capturing its result.
module alu_op_issuer #(
    parameter int W          = 8,
    parameter int ADD_WAIT   = 3,
    parameter int PASS_WAIT  = 1,
    parameter int OPCHG_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_op_issuer_if.slave bus,
    output logic [W-1:0]  alu_i1,
    output logic [W-1:0]  alu_i2,
    output logic [1:0]    alu_opcode,
    input  logic [W-1:0]  alu_o1,
    output logic          busy
);
    localparam int MAXW = (ADD_WAIT > PASS_WAIT) ? ADD_WAIT : PASS_WAIT;
    localparam int MAXN = MAXW + OPCHG_WAIT;
    localparam int CW   = (MAXN < 2) ? 1 : $clog2(MAXN + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t       state, state_n;
    logic [W-1:0] i1_n, i2_n, data_q, data_n;
    logic [1:0]   opc_n, last_op, last_op_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW:0]  opw, nsum;
    logic         vld_q, vld_n, err_q, err_n;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);

    always_comb begin
        state_n   = state;
        i1_n      = alu_i1;
        i2_n      = alu_i2;
        opc_n     = alu_opcode;
        last_op_n = last_op;
        cnt_n     = cnt;
        vld_n     = vld_q;
        data_n    = data_q;
        err_n     = err_q;

        // settle time; opcode-change penalty only when the macro sees a new op
        opw  = (bus.req_op == 2'b00) ? (CW+1)'(ADD_WAIT)
                                     : (CW+1)'(PASS_WAIT);
        nsum = opw + ((bus.req_op != last_op) ? (CW+1)'(OPCHG_WAIT) : '0);
        if (nsum == '0) begin
            nsum = (CW+1)'(1);
        end

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op != 2'b11) begin
                        i1_n      = bus.req_a;
                        i2_n      = bus.req_b;
                        opc_n     = bus.req_op;
                        last_op_n = bus.req_op;
                        cnt_n     = nsum[CW-1:0];
                        state_n   = DRIVE;
                    end else begin
                        data_n  = '0;
                        err_n   = 1'b1;
                        vld_n   = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            DRIVE: begin
                if (cnt == CW'(1)) begin
                    data_n  = alu_o1;
                    err_n   = 1'b0;
                    vld_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    vld_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_i1     <= '0;
            alu_i2     <= '0;
            alu_opcode <= 2'b00;
            last_op    <= 2'b00;
            cnt        <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            alu_i1     <= i1_n;
            alu_i2     <= i2_n;
            alu_opcode <= opc_n;
            last_op    <= last_op_n;
            cnt        <= cnt_n;
            vld_q      <= vld_n;
            data_q     <= data_n;
            err_q      <= err_n;
        end
    end
endmodule
